// File: rtl/watch_adj_arbiter.sv
// watch_adj_arbiter: round-robin arbiter of button/UART time-adjust requests onto spaced single-cycle increment pulses
module watch_adj_arbiter #(
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [2:0] i_btn_req,
    input  logic [2:0] i_uart_req,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic       o_btn_ack,
    output logic       o_uart_ack,
    output logic [2:0] o_btn_pend,
    output logic [2:0] o_uart_pend,
    output logic       o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t     r_state, w_next;
    logic [2:0] r_btn_pend, r_uart_pend, r_inc, w_src_pend, w_unit;
    logic       r_btn_ack, r_uart_ack, r_last_uart, w_pick_uart, w_grant;
    logic [7:0] r_cnt;
    assign w_pick_uart = |r_uart_pend && (!(|r_btn_pend) || !r_last_uart);
    assign w_src_pend  = w_pick_uart ? r_uart_pend : r_btn_pend;
    assign w_unit      = w_src_pend[2] ? 3'b100 : w_src_pend[1] ? 3'b010 : {2'b00, w_src_pend[0]};
    assign w_grant     = r_state == IDLE && i_en && |{r_btn_pend, r_uart_pend};
    always_comb begin
        w_next = (r_state == IDLE)  ? (w_grant ? ISSUE : IDLE) :
                 (r_state == ISSUE) ? (GAP_CYC == 1 ? IDLE : GAP) :
                                      (r_cnt == 8'd1 ? IDLE : GAP);
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    // r_inc and the acks double as the registered grant during ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inc       <= '0;
            r_btn_ack   <= 1'b0;
            r_uart_ack  <= 1'b0;
            r_btn_pend  <= '0;
            r_uart_pend <= '0;
            r_last_uart <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_inc       <= w_grant ? w_unit : 3'b000;
            r_btn_ack   <= w_grant && !w_pick_uart;
            r_uart_ack  <= w_grant && w_pick_uart;
            r_btn_pend  <= (r_btn_pend & ~(r_btn_ack ? r_inc : 3'b000)) | i_btn_req;
            r_uart_pend <= (r_uart_pend & ~(r_uart_ack ? r_inc : 3'b000)) | i_uart_req;
            r_last_uart <= (r_state == ISSUE) ? r_uart_ack : r_last_uart;
            r_cnt       <= (r_state == ISSUE) ? 8'(GAP_CYC - 1) : (r_state == GAP) ? r_cnt - 8'd1 : r_cnt;
        end
    end
    assign o_inc_sec   = r_inc[0];
    assign o_inc_min   = r_inc[1];
    assign o_inc_hour  = r_inc[2];
    assign o_btn_ack   = r_btn_ack;
    assign o_uart_ack  = r_uart_ack;
    assign o_btn_pend  = r_btn_pend;
    assign o_uart_pend = r_uart_pend;
    assign o_busy      = r_state != IDLE;
endmodule

// File: tb/tb_watch_adj_arbiter.sv
// tb_watch_adj_arbiter: directed and random checks against a time-based reference model
module tb_watch_adj_arbiter;
    localparam int GAP = 4;
    logic       clk = 1'b0;
    logic       rst, i_en;
    logic [2:0] i_btn_req, i_uart_req;
    logic       o_inc_sec, o_inc_min, o_inc_hour, o_btn_ack, o_uart_ack, o_busy;
    logic [2:0] o_btn_pend, o_uart_pend;

    watch_adj_arbiter #(.GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_btn_req(i_btn_req), .i_uart_req(i_uart_req),
        .o_inc_sec(o_inc_sec), .o_inc_min(o_inc_min), .o_inc_hour(o_inc_hour),
        .o_btn_ack(o_btn_ack), .o_uart_ack(o_uart_ack),
        .o_btn_pend(o_btn_pend), .o_uart_pend(o_uart_pend), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc_n = 0;
    int last_pulse = -1000;
    bit m_last_uart = 1'b1;
    bit m_ba = 1'b0, m_ua = 1'b0;
    logic [2:0] m_bp = '0, m_up = '0, m_inc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic logic [2:0] highest(input logic [2:0] p);
        for (int i = 2; i >= 0; i--)
            if (p[i]) return 3'(1 << i);
        return 3'b000;
    endfunction

    // A grant may be decided in cycle c only when GAP cycles have elapsed since the last pulse
    task automatic model_edge();
        bit g, gu;
        logic [2:0] nb, nu;
        if (rst) begin
            m_bp = '0; m_up = '0; m_inc = '0; m_ba = 0; m_ua = 0;
            m_last_uart = 1; last_pulse = -1000;
        end else begin
            g  = (cyc_n - last_pulse >= GAP) && i_en && (m_bp != 0 || m_up != 0);
            gu = (m_up != 0) && (m_bp == 0 || !m_last_uart);
            nb = m_ba ? (m_bp & ~m_inc) : m_bp;
            nu = m_ua ? (m_up & ~m_inc) : m_up;
            if (m_ba || m_ua) m_last_uart = m_ua;
            m_inc = g ? highest(gu ? m_up : m_bp) : 3'b000;
            m_ba  = g && !gu;
            m_ua  = g && gu;
            if (g) last_pulse = cyc_n + 1;
            m_bp = nb | i_btn_req;
            m_up = nu | i_uart_req;
        end
        cyc_n++;
    endtask

    task automatic compare();
        chk("inc", {29'd0, o_inc_hour, o_inc_min, o_inc_sec}, {29'd0, m_inc});
        chk("ack", {30'd0, o_btn_ack, o_uart_ack}, {30'd0, m_ba, m_ua});
        chk("btn_pend", {29'd0, o_btn_pend}, {29'd0, m_bp});
        chk("uart_pend", {29'd0, o_uart_pend}, {29'd0, m_up});
        chk("busy", {31'd0, o_busy}, {31'd0, (cyc_n - last_pulse < GAP)});
        chk("onehot_inc", {31'd0, $onehot0({o_inc_hour, o_inc_min, o_inc_sec})}, 32'd1);
    endtask

    task automatic cyc(input logic [2:0] b, input logic [2:0] u, input logic en, input logic r);
        i_btn_req = b; i_uart_req = u; i_en = en; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(3'b000, 3'b000, 1'b1, 1'b0);
    endtask

    initial begin
        i_btn_req = '0; i_uart_req = '0; i_en = 1'b1; rst = 1'b1;
        #1;
        // reset held with requests present: nothing must survive
        cyc(3'b111, 3'b000, 1'b1, 1'b1);
        cyc(3'b111, 3'b000, 1'b1, 1'b1);
        cyc(3'b111, 3'b000, 1'b1, 1'b1);
        chk("t1_pend", {29'd0, o_btn_pend}, 32'd0);
        idle(10);
        chk("t1_busy", {31'd0, o_busy}, 32'd0);
        // single button seconds request
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        cyc(3'b001, 3'b000, 1'b1, 1'b0);
        chk("t2_pend_c1", {29'd0, o_btn_pend}, 32'd1);
        cyc(3'b000, 3'b000, 1'b1, 1'b0);
        chk("t2_inc_c2", {30'd0, o_inc_sec, o_btn_ack}, 32'd3);
        cyc(3'b000, 3'b000, 1'b1, 1'b0);
        chk("t2_pend_c3", {29'd0, o_btn_pend}, 32'd0);
        chk("t2_busy_c3", {31'd0, o_busy}, 32'd1);
        idle(8);
        // round robin: btn hour, uart min, btn sec
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        cyc(3'b101, 3'b010, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc(3'b000, 3'b000, 1'b1, 1'b0);
            if (k + 1 == 2)  chk("t3_btn_hour", {30'd0, o_inc_hour, o_btn_ack}, 32'd3);
            if (k + 1 == 7)  chk("t3_uart_min", {30'd0, o_inc_min, o_uart_ack}, 32'd3);
            if (k + 1 == 12) chk("t3_btn_sec", {30'd0, o_inc_sec, o_btn_ack}, 32'd3);
        end
        idle(6);
        // merged requests, then a re-request during ISSUE
        cyc(3'b001, 3'b000, 1'b1, 1'b0);
        cyc(3'b001, 3'b000, 1'b1, 1'b0);
        chk("t4_first", {31'd0, o_inc_sec}, 32'd1);
        cyc(3'b001, 3'b000, 1'b1, 1'b0);
        chk("t4_still_pend", {29'd0, o_btn_pend}, 32'd1);
        for (int k = 3; k <= 6; k++) cyc(3'b000, 3'b000, 1'b1, 1'b0);
        chk("t4_second", {31'd0, o_inc_sec}, 32'd1);
        idle(6);
        // disabled: hold pending until enable returns
        cyc(3'b000, 3'b100, 1'b0, 1'b0);
        chk("t5_pend", {29'd0, o_uart_pend}, 32'd4);
        for (int k = 1; k <= 19; k++) cyc(3'b000, 3'b000, 1'b0, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 1'b0);
        chk("t5_hour", {30'd0, o_inc_hour, o_uart_ack}, 32'd3);
        idle(6);
        // reset in second GAP cycle
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        cyc(3'b100, 3'b011, 1'b1, 1'b0);
        idle(3);
        chk("t6_pend_before", {29'd0, o_uart_pend}, 32'd3);
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        chk("t6_pend_after", {26'd0, o_btn_pend, o_uart_pend}, 32'd0);
        chk("t6_busy_after", {31'd0, o_busy}, 32'd0);
        idle(10);
        // random traffic
        for (int k = 0; k < 3000; k++)
            cyc(($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 299) == 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/watch_adj_arbiter.md
Name: watch_adj_arbiter

Overview:
- Arbitrates time-adjust requests from two sources, the debounced front-panel buttons and the UART command decoder, onto the shared sec/min/hour increment inputs of the watch datapath.
- Latches requests as pending flags and grants one source per slot, round-robin.
- Issues exactly one single-cycle increment pulse per grant, then enforces a minimum gap before the next pulse.
- Sits between the button/UART front ends and the watch counter.

Parameters:
GAP_CYC, 4, gap cycles after each issued pulse before the next grant (legal 1..255); pulse-to-pulse spacing is GAP_CYC+1 cycles.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
i_en  input  1  1 = grants allowed; 0 = hold pending, issue nothing new
i_btn_req  input  3  button requests, one-cycle pulses; bit0 sec, bit1 min, bit2 hour
i_uart_req  input  3  UART requests, same encoding
o_inc_sec  output  1  one-cycle seconds increment pulse to datapath
o_inc_min  output  1  one-cycle minutes increment pulse
o_inc_hour  output  1  one-cycle hours increment pulse
o_btn_ack  output  1  one-cycle pulse, coincident with an inc pulse granted to buttons
o_uart_ack  output  1  one-cycle pulse, coincident with an inc pulse granted to UART
o_btn_pend  output  3  button pending flags
o_uart_pend  output  3  UART pending flags
o_busy  output  1  1 when state is not IDLE

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; all pending flags, all o_inc_*, and both acks = 0.
  - last_served=UART, so buttons win the first tie.
  - Requests present while rst=1 are discarded.
- Pending flags:
  - A pend bit is set at the edge after its req bit is 1.
  - It is cleared at the edge ending the ISSUE cycle that serves it.
  - A req for the same bit during its own ISSUE cycle keeps it set, counting as a new request.
  - Repeated reqs while already pending merge into one; no counting.
- State IDLE:
  - If i_en=1 and any pend bit is set, select a source.
    - Both sources pending: take the one not equal to last_served.
    - Only one source pending: take that one.
  - Within the chosen source, unit priority is hour > min > sec.
  - Register the grant (source, unit) and go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - Exactly one o_inc_* = 1, plus the ack of the granted source.
  - Clear the served pend bit and set last_served = granted source.
  - If GAP_CYC=1, go to IDLE; else load gap counter with GAP_CYC-1 and go to GAP.
- State GAP:
  - Decrement the counter each cycle; at 0, go to IDLE.
  - Requests keep latching during GAP.
- Outputs:
  - o_inc_* and acks are registered and high only in ISSUE.
  - Never more than one o_inc_* high in any cycle.
- Latency:
  - A req pulse in cycle t with state IDLE and i_en=1 gives pend visible in t+1 and the inc pulse in t+2.
  - Spacing between consecutive pulses is at least GAP_CYC+1 cycles.
- i_en:
  - Sampled only in IDLE.
  - i_en falling during ISSUE or GAP does not abort; the sequence completes to IDLE.
- Reset mid-operation (ISSUE or GAP): next cycle is IDLE with everything cleared; the pulse in progress is truncated after that cycle.
- o_busy = (state != IDLE).

Test Plan:
1. Hold rst=1 for 3 cycles with i_btn_req=3'b111 pulsed -> after release, all outputs 0 and no inc pulses ever issue.
2. i_btn_req=3'b001 pulse in cycle 0, i_en=1 -> o_btn_pend[0]=1 in cycle 1; o_inc_sec=o_btn_ack=1 only in cycle 2; o_btn_pend=0 in cycle 3; o_busy=1 in cycles 2..5.
3. GAP_CYC=4, cycle 0: i_btn_req=3'b101 and i_uart_req=3'b010 -> btn hour in cycle 2, uart min in cycle 7, btn sec in cycle 12; each with the correct ack; no other pulses.
4. i_btn_req[0] pulsed in cycles 0 and 1 -> single o_inc_sec in cycle 2. Repeat the pulse in cycle 2 -> second o_inc_sec in cycle 7 (GAP_CYC=4).
5. i_en=0; pulse i_uart_req=3'b100 in cycle 0 -> o_uart_pend=3'b100, no pulses through cycle 20. Raise i_en in cycle 20 -> o_inc_hour with o_uart_ack in cycle 21.
6. Assert rst in the second GAP cycle with o_uart_pend=3'b011 -> next cycle pending=0, o_busy=0, and no further pulses.
